// File: rtl/m2_block_fetch.sv
// m2_block_fetch
//   Fetches one BLOCK_DIM x BLOCK_DIM block of signed 16-bit pre-IDCT samples
//   for channel Y, U or V from external SRAM. The samples are written row-major
//   into an embedded dual-port RAM through port B. A start/done handshake
//   with the coordinator frames each transfer.
//
// Ports
//   CLOCK_50_I      system clock
//   Reset           synchronous, active-high reset
//   start           transfer request, sampled only in IDLE
//   channel         0=Y 1=U 2=V 3=illegal (flags err, no transfer)
//   block_col/row   block coordinates, latched with start
//   SRAM_address    registered SRAM read address (0 when not issuing)
//   SRAM_we_n       tied high, this block only reads
//   SRAM_read_data  SRAM data, valid SRAM_LAT cycles after its address
//   wr_address/data RAM port-B address and data; both hold between writes
//   wr_enable       RAM port-B write strobe
//   busy            high whenever not IDLE
//   done            one-cycle completion pulse
//   err             last accepted request had an illegal channel
module m2_block_fetch #(
  parameter int BLOCK_DIM = 8,
  parameter int SRAM_LAT  = 2,
  parameter int Y_BASE    = 76800,
  parameter int U_BASE    = 153600,
  parameter int V_BASE    = 192000,
  parameter int Y_WIDTH   = 320,
  parameter int UV_WIDTH  = 160,
  parameter int PACK      = 0,
  parameter int WADDR_W   = 7
) (
  input  logic               CLOCK_50_I,
  input  logic               Reset,
  input  logic               start,
  input  logic [1:0]         channel,
  input  logic [5:0]         block_col,
  input  logic [4:0]         block_row,
  output logic [17:0]        SRAM_address,
  output logic               SRAM_we_n,
  input  logic [15:0]        SRAM_read_data,
  output logic [WADDR_W-1:0] wr_address,
  output logic [31:0]        wr_data,
  output logic               wr_enable,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int LOG2BD = $clog2(BLOCK_DIM);
  localparam int KW     = 2 * LOG2BD;                      // sample index width, N2 = 2**KW
  localparam int SRW    = (SRAM_LAT > 0) ? SRAM_LAT : 1;   // read-valid shift register width
  localparam int DCW    = (SRAM_LAT > 0) ? $clog2(SRAM_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [1:0]       r_ch;
  logic [KW-1:0]    r_ik;         // index of the sample whose address is on the bus
  logic [KW-1:0]    r_ck;         // index of the next sample to be captured
  logic [17:0]      r_row_start;  // address of column 0 in the current row
  logic [17:0]      r_addr;
  logic [DCW-1:0]   r_dcnt;
  logic [SRW-1:0]   r_vld_sr;     // one bit per read in flight
  logic [15:0]      r_even;
  logic             r_err;
  logic [WADDR_W-1:0] r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_wr_en;

  logic             w_accept;
  logic             w_issue;
  logic             w_cap;
  logic             w_row_end;
  logic             w_last_issue;
  logic [17:0]      w_row_px;
  logic [17:0]      w_col_px;
  logic [17:0]      w_y_start;
  logic [17:0]      w_u_start;
  logic [17:0]      w_v_start;
  logic [17:0]      w_start;
  logic [17:0]      w_pitch;

  // First sample address. The plane widths are constants, so each product is
  // a constant multiply. The channel selects between finished addresses, so
  // no runtime multiplier is needed. The 18-bit arithmetic gives the
  // required wrap.
  assign w_row_px  = 18'(block_row) << LOG2BD;
  assign w_col_px  = 18'(block_col) << LOG2BD;
  assign w_y_start = 18'(Y_BASE) + w_row_px * 18'(Y_WIDTH)  + w_col_px;
  assign w_u_start = 18'(U_BASE) + w_row_px * 18'(UV_WIDTH) + w_col_px;
  assign w_v_start = 18'(V_BASE) + w_row_px * 18'(UV_WIDTH) + w_col_px;

  always_comb begin
    w_start = 18'd0;
    case (channel)
      2'd0:    w_start = w_y_start;
      2'd1:    w_start = w_u_start;
      2'd2:    w_start = w_v_start;
      default: w_start = 18'd0;
    endcase
  end

  assign w_pitch      = (r_ch == 2'd0) ? 18'(Y_WIDTH) : 18'(UV_WIDTH);
  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_issue      = (r_state == S_ISSUE);
  assign w_row_end    = &r_ik[LOG2BD-1:0];
  assign w_last_issue = &r_ik;
  // A sample is on SRAM_read_data SRAM_LAT cycles after its address.
  assign w_cap        = (SRAM_LAT == 0) ? w_issue : r_vld_sr[SRW-1];

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (channel == 2'd3) ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (r_dcnt == DCW'(SRAM_LAT)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Address generation and read pipeline
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      r_ch        <= 2'd0;
      r_ik        <= '0;
      r_row_start <= 18'd0;
      r_addr      <= 18'd0;
      r_dcnt      <= '0;
      r_vld_sr    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_vld_sr <= (r_vld_sr << 1) | SRW'(w_issue);
      r_dcnt   <= (r_state == S_DRAIN) ? r_dcnt + DCW'(1) : '0;
      if (w_accept) begin
        r_err       <= (channel == 2'd3);
        r_ch        <= channel;
        r_ik        <= '0;
        r_row_start <= w_start;
        r_addr      <= w_start;          // zero for the illegal channel
      end else if (w_issue) begin
        r_ik <= r_ik + KW'(1);
        if (w_last_issue) begin
          r_addr <= 18'd0;
        end else if (w_row_end) begin
          r_row_start <= r_row_start + w_pitch;
          r_addr      <= r_row_start + w_pitch;
        end else begin
          r_addr <= r_addr + 18'd1;
        end
      end
    end
  end

  // Capture and port-B write
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      r_ck      <= '0;
      r_even    <= 16'd0;
      r_wr_addr <= '0;
      r_wr_data <= 32'd0;
      r_wr_en   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_cap) begin
        r_ck <= r_ck + KW'(1);
        if (PACK == 0) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= WADDR_W'(r_ck);
          r_wr_data <= {{16{SRAM_read_data[15]}}, SRAM_read_data};
        end else if (!r_ck[0]) begin
          r_even <= SRAM_read_data;      // even sample waits for its odd partner
        end else begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= WADDR_W'(r_ck >> 1);
          r_wr_data <= {r_even, SRAM_read_data};
        end
      end else if (w_accept) begin
        r_ck <= '0;
      end
    end
  end

  assign SRAM_address = r_addr;
  assign SRAM_we_n    = 1'b1;
  assign wr_address   = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign wr_enable    = r_wr_en;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err          = r_err;

endmodule

// File: tb/tb_m2_block_fetch.sv
// Bench for m2_block_fetch: a PACK=0 and a PACK=1 instance share one stimulus.
// A transfer-level model predicts every output on every cycle. Directed
// literal checks pin the model to hand-computed addresses and timing.
module tb_m2_block_fetch;
  localparam int BD  = 8;
  localparam int LAT = 2;
  localparam int N2  = BD * BD;
  localparam int YB  = 76800;
  localparam int UB  = 153600;
  localparam int VB  = 192000;
  localparam int YW  = 320;
  localparam int UVW = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [1:0]  ch;
  logic [5:0]  col;
  logic [4:0]  row;
  logic [17:0] a0, a1;
  logic        we0, we1;
  logic [15:0] rd0, rd1;
  logic [6:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        wen0, wen1, busy0, busy1, done0, done1, err0, err1;

  m2_block_fetch #(.PACK(0)) u0 (
    .CLOCK_50_I(clk), .Reset(rst), .start(start), .channel(ch),
    .block_col(col), .block_row(row), .SRAM_address(a0), .SRAM_we_n(we0),
    .SRAM_read_data(rd0), .wr_address(wa0), .wr_data(wd0), .wr_enable(wen0),
    .busy(busy0), .done(done0), .err(err0));

  m2_block_fetch #(.PACK(1)) u1 (
    .CLOCK_50_I(clk), .Reset(rst), .start(start), .channel(ch),
    .block_col(col), .block_row(row), .SRAM_address(a1), .SRAM_we_n(we1),
    .SRAM_read_data(rd1), .wr_address(wa1), .wr_data(wd1), .wr_enable(wen1),
    .busy(busy1), .done(done1), .err(err1));

  // SRAM content: a seeded hash of the address, with two overridable words
  logic [31:0] seed = 32'h1357_9bdf;
  bit          ov_en = 1'b0;
  logic [17:0] ov_a0 = 18'd0, ov_a1 = 18'd0;
  logic [15:0] ov_v0 = 16'd0, ov_v1 = 16'd0;

  function automatic logic [15:0] f(input logic [17:0] a);
    logic [31:0] h;
    if (ov_en && a == ov_a0) return ov_v0;
    if (ov_en && a == ov_a1) return ov_v1;
    h = ({14'd0, a} * 32'h9E37_79B1) ^ seed;
    return h[31:16] ^ h[15:0];
  endfunction

  // Two-cycle read latency: address in cycle t, data valid during t+2
  logic [17:0] a0_d, a1_d;
  always @(posedge clk) begin
    a0_d <= a0;
    a1_d <= a1;
    rd0  <= f(a0_d);
    rd1  <= f(a1_d);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_n = 0, tot_n = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Transfer-level model
  bit          armed = 1'b0;
  bit          m_act = 1'b0;
  int          m_t0 = 0, m_dn = 0;
  logic [1:0]  m_ch = 2'd0;
  logic [5:0]  m_col = 6'd0;
  logic [4:0]  m_row = 5'd0;
  logic        m_err = 1'b0;
  logic [6:0]  e_wa0 = 7'd0, e_wa1 = 7'd0;
  logic [31:0] e_wd0 = 32'd0, e_wd1 = 32'd0;
  int          nw0 = 0, nw1 = 0;

  function automatic bit m_idle(input int c);
    return !m_act || c > m_dn;
  endfunction

  function automatic logic [17:0] maddr(input int k);
    longint base, w, v;
    base = (m_ch == 2'd0) ? YB : (m_ch == 2'd1) ? UB : VB;
    w    = (m_ch == 2'd0) ? YW : UVW;
    v    = base + (longint'(m_row) * BD + k / BD) * w + longint'(m_col) * BD + k % BD;
    return v[17:0];
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] s);
    return {{16{s[15]}}, s};
  endfunction

  always @(negedge clk) begin : compare
    logic        e_busy, e_done, e_wen0, e_wen1;
    logic [17:0] e_a;
    int          d, kw;
    if (armed) begin
      e_busy = 1'b0; e_done = 1'b0; e_wen0 = 1'b0; e_wen1 = 1'b0; e_a = 18'd0;
      if (!m_idle(cyc)) begin
        d      = cyc - m_t0;
        e_busy = 1'b1;
        e_done = (cyc == m_dn);
        if (m_ch != 2'd3) begin
          if (d >= 1 && d <= N2) e_a = maddr(d - 1);
          kw = d - 2 - LAT;
          if (kw >= 0 && kw < N2) begin
            e_wen0 = 1'b1;
            e_wa0  = 7'(kw);
            e_wd0  = sext(f(maddr(kw)));
            if (kw % 2 == 1) begin
              e_wen1 = 1'b1;
              e_wa1  = 7'(kw / 2);
              e_wd1  = {f(maddr(kw - 1)), f(maddr(kw))};
            end
          end
        end
      end
      chk("busy0", 32'(busy0), 32'(e_busy));
      chk("busy1", 32'(busy1), 32'(e_busy));
      chk("done0", 32'(done0), 32'(e_done));
      chk("done1", 32'(done1), 32'(e_done));
      chk("err0",  32'(err0),  32'(m_err));
      chk("err1",  32'(err1),  32'(m_err));
      chk("addr0", 32'(a0),    32'(e_a));
      chk("addr1", 32'(a1),    32'(e_a));
      chk("wen0",  32'(wen0),  32'(e_wen0));
      chk("wen1",  32'(wen1),  32'(e_wen1));
      chk("wa0",   32'(wa0),   32'(e_wa0));
      chk("wa1",   32'(wa1),   32'(e_wa1));
      chk("wd0",   wd0,        e_wd0);
      chk("wd1",   wd1,        e_wd1);
      chk("we_n0", 32'(we0),   32'd1);
      chk("we_n1", 32'(we1),   32'd1);
    end
    if (wen0 === 1'b1) nw0++;
    if (wen1 === 1'b1) nw1++;
    // Inputs of this cycle decide the state of the next one
    if (rst) begin
      armed = 1'b1; m_act = 1'b0; m_err = 1'b0;
      e_wa0 = 7'd0; e_wa1 = 7'd0; e_wd0 = 32'd0; e_wd1 = 32'd0;
    end else if (armed && m_idle(cyc) && start) begin
      m_act = 1'b1; m_t0 = cyc; m_ch = ch; m_col = col; m_row = row;
      m_err = (ch == 2'd3);
      m_dn  = (ch == 2'd3) ? cyc + 1 : cyc + 2 + N2 + LAT;
    end
  end

  // Stimulus helpers: tick lands 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic go(input logic [1:0] c, input int cl, input int rw, output int t0);
    int n = 0;
    while (!m_idle(cyc) && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      tot_n++;
      $display("FAIL go_timeout cycle %0d: still busy after %0d cycles, required idle", cyc, n);
    end
    start = 1'b1; ch = c; col = 6'(cl); row = 5'(rw);
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!m_idle(cyc) && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      tot_n++;
      $display("FAIL idle_timeout cycle %0d: still busy after %0d cycles, required idle", cyc, n);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stim
    int t0, t1;
    rst = 1'b1; start = 1'b0; ch = 2'd0; col = 6'd0; row = 5'd0;
    repeat (3) tick();
    rst = 1'b0;
    at_neg(cyc);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err",  32'(err0),  32'd0);
    chk("rst_addr", 32'(a0),    32'd0);
    chk("rst_wen",  32'(wen0),  32'd0);
    chk("rst_wd",   wd0,        32'd0);
    tick();

    // Y block (0,0), sample 0 = 0x8001
    ov_en = 1'b1; ov_a0 = 18'd76800; ov_v0 = 16'h8001; ov_a1 = 18'd76801; ov_v1 = 16'h0007;
    nw0 = 0; nw1 = 0;
    go(2'd0, 0, 0, t0);
    at_neg(t0 + 1);  chk("y_first", 32'(a0), 32'd76800); chk("y_busy", 32'(busy0), 32'd1);
    at_neg(t0 + 4);  chk("y_w0_en", 32'(wen0), 32'd1); chk("y_w0_a", 32'(wa0), 32'd0);
                     chk("y_w0_d", wd0, 32'hFFFF8001);
    at_neg(t0 + 9);  chk("y_row1", 32'(a0), 32'd77120);
    at_neg(t0 + 64); chk("y_last", 32'(a0), 32'd79047);
    at_neg(t0 + 65); chk("y_addr0", 32'(a0), 32'd0);
    at_neg(t0 + 67); chk("y_lastw", 32'(wa0), 32'd63); chk("y_lastw_en", 32'(wen0), 32'd1);
    at_neg(t0 + 68); chk("y_done", 32'(done0), 32'd1);
                     chk("y_nw0", 32'(nw0), 32'd64); chk("y_nw1", 32'(nw1), 32'd32);
    at_neg(t0 + 69); chk("y_idle", 32'(busy0), 32'd0); chk("y_done_off", 32'(done0), 32'd0);
    tick();

    // U block (19,14)
    ov_en = 1'b0; seed = $urandom;
    go(2'd1, 19, 14, t0);
    at_neg(t0 + 1);  chk("u_first", 32'(a0), 32'd171672); chk("u_busy_s", 32'(busy0), 32'd1);
    at_neg(t0 + 9);  chk("u_row1", 32'(a0), 32'd171832);
    at_neg(t0 + 64); chk("u_last", 32'(a0), 32'd172799);
    at_neg(t0 + 68); chk("u_busy_e", 32'(busy0), 32'd1);
    at_neg(t0 + 69); chk("u_idle", 32'(busy0), 32'd0);
    tick();

    // Packing: samples 0x1234 and 0xABCD at indices 0 and 1
    ov_en = 1'b1; ov_a0 = 18'd76800; ov_v0 = 16'h1234; ov_a1 = 18'd76801; ov_v1 = 16'hABCD;
    nw1 = 0;
    go(2'd0, 0, 0, t0);
    at_neg(t0 + 4);  chk("p_even_held", 32'(wen1), 32'd0);
    at_neg(t0 + 5);  chk("p_w0_en", 32'(wen1), 32'd1); chk("p_w0_a", 32'(wa1), 32'd0);
                     chk("p_w0_d", wd1, 32'h1234ABCD);
    at_neg(t0 + 67); chk("p_lastw", 32'(wa1), 32'd31); chk("p_lastw_en", 32'(wen1), 32'd1);
    at_neg(t0 + 68); chk("p_nw1", 32'(nw1), 32'd32);
    tick();

    // Illegal channel, then a legal start clears err
    ov_en = 1'b0; seed = $urandom;
    nw0 = 0; nw1 = 0;
    go(2'd3, 5, 5, t0);
    at_neg(t0 + 1); chk("i_done", 32'(done0), 32'd1); chk("i_err", 32'(err0), 32'd1);
                    chk("i_addr", 32'(a0), 32'd0);
    at_neg(t0 + 2); chk("i_idle", 32'(busy0), 32'd0); chk("i_err_hold", 32'(err0), 32'd1);
                    chk("i_nw", 32'(nw0 + nw1), 32'd0);
    tick();
    go(2'd2, 1, 1, t1);
    at_neg(t1 + 1); chk("i_err_clr", 32'(err0), 32'd0);
    tick();

    // Reset in the middle of a transfer
    wait_idle();
    go(2'd0, 3, 2, t0);
    at_neg(t0 + 19);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nw0 = 0; nw1 = 0;
    at_neg(t0 + 21); chk("r_busy", 32'(busy0), 32'd0); chk("r_wen", 32'(wen0), 32'd0);
    at_neg(t0 + 80); chk("r_nw", 32'(nw0 + nw1), 32'd0);
    tick();
    go(2'd0, 3, 2, t1);
    at_neg(t1 + 1); chk("r_restart", 32'(a0), 32'd81944);
    at_neg(t1 + 4); chk("r_w0_a", 32'(wa0), 32'd0); chk("r_w0_en", 32'(wen0), 32'd1);
    tick();

    // Starts while busy are ignored; start the cycle after done is accepted
    wait_idle();
    go(2'd1, 2, 3, t0);
    at_neg(t0 + 9);
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    at_neg(t0 + 67);
    tick(); start = 1'b1; ch = 2'd0; col = 6'd0; row = 5'd0;
    tick(); ch = 2'd2; col = 6'd1; row = 5'd1;
    tick(); start = 1'b0;
    at_neg(t0 + 70); chk("s_accept", 32'(a0), 32'd193288); chk("s_busy", 32'(busy0), 32'd1);
    tick();

    // start held high: back-to-back transfers
    wait_idle();
    start = 1'b1; ch = 2'd0; col = 6'd1; row = 5'd0;
    t0 = cyc;
    at_neg(t0 + 69); chk("b_gap", 32'(busy0), 32'd0);
    at_neg(t0 + 70); chk("b_next", 32'(a0), 32'd76808);
    tick();
    while (cyc < t0 + 200) tick();
    start = 1'b0;

    // Random phase: the model checks every cycle
    wait_idle();
    seed = $urandom;
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 5) == 0);
      ch    = 2'($urandom);
      col   = 6'($urandom);
      row   = 5'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (100) tick();

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
